// File: rtl/atm_request_sequencer.sv
// Sequences one host request (balance/withdraw/deposit/change-pin) through the ATM
// phases and returns a one-cycle response with a status code and the captured result.
module atm_request_sequencer #(
  parameter int          TIMEOUT  = 16,
  parameter logic [3:0]  ACC_NONE = 4'hF,
  parameter logic [2:0]  OP_NONE  = 3'd7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [3:0]  req_acc,
  input  logic [15:0] req_pin,
  input  logic [15:0] req_new_pin,
  input  logic [31:0] req_amount,
  input  logic        req_language,
  output logic [2:0]  operation,
  output logic [3:0]  acc_num,
  output logic [15:0] pin,
  output logic [15:0] newPin,
  output logic [31:0] amount,
  output logic        language,
  input  logic [2:0]  atm_state,
  input  logic        atm_success,
  input  logic [31:0] atm_balance,
  output logic        rsp_valid,
  output logic [1:0]  rsp_code,
  output logic        rsp_success,
  output logic [31:0] rsp_balance
);
  // Ops: BALANCE=0 WITHDRAW=1 DEPOSIT=2 CHANGE_PIN=3.
  // ATM states: WAITING=0 AUTHENTICATION=1 MENU=2, then one state per op (BALANCE=3 .. CHANGE_PIN=6).
  localparam logic [2:0] OP_CHANGE_PIN     = 3'd3;
  localparam logic [2:0] ST_WAITING        = 3'd0;
  localparam logic [2:0] ST_AUTHENTICATION = 3'd1;
  localparam logic [2:0] ST_MENU           = 3'd2;
  localparam logic [2:0] ST_BALANCE        = 3'd3;

  localparam logic [1:0] RSP_OK        = 2'b00;
  localparam logic [1:0] RSP_AUTH_FAIL = 2'b01;
  localparam logic [1:0] RSP_TIMEOUT   = 2'b10;
  localparam logic [1:0] RSP_BAD_OP    = 2'b11;

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_PRESENT, S_AUTH, S_MENU_WAIT, S_OP_WAIT, S_DONE_WAIT, S_RESPOND
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt;
  logic [2:0]    op_r;
  logic [1:0]    code_n;
  logic          accept, expired, counting;
  logic          latch_success, latch_bal;
  logic [2:0]    op_state;

  assign req_ready = (state == S_IDLE);
  assign rsp_valid = (state == S_RESPOND);
  assign accept    = req_valid & req_ready;
  assign expired   = (cnt == CW'(TIMEOUT - 1));
  assign op_state  = ST_BALANCE + op_r;
  assign counting  = (state == S_PRESENT) || (state == S_AUTH) ||
                     (state == S_MENU_WAIT) || (state == S_DONE_WAIT);

  // Awaited condition is tested before expiry so a same-cycle hit still wins.
  always_comb begin
    state_n       = state;
    code_n        = rsp_code;
    latch_success = 1'b0;
    latch_bal     = 1'b0;
    case (state)
      S_IDLE:
        if (accept) begin
          if (req_op <= OP_CHANGE_PIN) state_n = S_PRESENT;
          else begin state_n = S_RESPOND; code_n = RSP_BAD_OP; end
        end
      S_PRESENT:
        if (atm_state == ST_AUTHENTICATION) state_n = S_AUTH;
        else if (expired) begin state_n = S_RESPOND; code_n = RSP_TIMEOUT; end
      S_AUTH:
        if (atm_state == ST_MENU) state_n = S_MENU_WAIT;
        else if (atm_state == ST_WAITING) begin state_n = S_RESPOND; code_n = RSP_AUTH_FAIL; end
        else if (expired) begin state_n = S_RESPOND; code_n = RSP_TIMEOUT; end
      S_MENU_WAIT:
        if (atm_state == op_state) begin state_n = S_DONE_WAIT; latch_success = 1'b1; end
        else if (expired) begin state_n = S_RESPOND; code_n = RSP_TIMEOUT; end
      S_DONE_WAIT:
        if (atm_state == ST_WAITING) begin
          state_n = S_RESPOND; code_n = RSP_OK; latch_bal = 1'b1;
        end else if (expired) begin state_n = S_RESPOND; code_n = RSP_TIMEOUT; end
      S_RESPOND: state_n = S_IDLE;
      default:   state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      op_r        <= OP_NONE;
      operation   <= OP_NONE;
      acc_num     <= ACC_NONE;
      pin         <= '0;
      newPin      <= '0;
      amount      <= '0;
      language    <= 1'b0;
      rsp_code    <= RSP_OK;
      rsp_success <= 1'b0;
      rsp_balance <= '0;
    end else begin
      state <= state_n;
      if (state_n != state) cnt <= '0;
      else if (counting)    cnt <= cnt + CW'(1);
      if (accept) op_r <= req_op;
      // A rejected op never reaches the ATM, so its fields are not driven.
      if (accept && state_n == S_PRESENT) begin
        acc_num  <= req_acc;
        pin      <= req_pin;
        newPin   <= req_new_pin;
        amount   <= req_amount;
        language <= req_language;
      end
      if (state == S_AUTH && state_n == S_MENU_WAIT) operation <= op_r;
      if (latch_success) rsp_success <= atm_success;
      if (latch_bal)     rsp_balance <= atm_balance;
      if (state_n == S_RESPOND) begin
        acc_num   <= ACC_NONE;
        operation <= OP_NONE;
        rsp_code  <= code_n;
        if (code_n != RSP_OK) rsp_success <= 1'b0;
      end
    end
  end
endmodule
